okdram_fifo: RTL and testbench

- Parametrised single-clock synchronous FIFO built on distributed (LUT) RAM: asynchronous-read storage array behind a registered output stage.
- Successor to the fixed 64x8 dual-port distributed-RAM primitive. Generalised in width and depth, adds pointer/occupancy management, threshold flags, sticky error flags and an optional first-word-fall-through (FWFT) mode.
- Used as a small rate-matching buffer between pipe/streaming endpoints and user logic in the same clock domain.

---
 rtl/okdram_fifo.sv | 106 ++++++++++
 tb/tb_okdram_fifo.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/okdram_fifo.sv
// okdram_fifo: single-clock FIFO on distributed RAM with registered output,
// occupancy flags, sticky error flags and optional first-word-fall-through.
module okdram_fifo #(
   parameter int WIDTH         = 8,
   parameter int AW            = 6,
   parameter int FWFT          = 0,
   parameter int AFULL_THRESH  = (1 << AW) - 4,
   parameter int AEMPTY_THRESH = 4
) (
   input  logic             wclk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   input  logic             rd_en,
   input  logic             clr_err,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             full,
   output logic             almost_full,
   output logic             empty,
   output logic             almost_empty,
   output logic [AW:0]      count,
   output logic             overflow,
   output logic             underflow
);

   localparam int          DEPTH    = 1 << AW;
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_AF   = (AW+1)'(AFULL_THRESH);
   localparam logic [AW:0] CNT_AE   = (AW+1)'(AEMPTY_THRESH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      ram_cnt;
   logic [AW:0]      count_nxt;
   logic             wr_acc;
   logic             ram_rd;
   logic             out_take;
   logic             dv_nxt;
   logic             ovf_evt;
   logic             unf_evt;

   // Accept/consume decisions and next-state occupancy from pre-edge flags
   always_comb begin
      ram_cnt   = count - (AW+1)'((FWFT != 0) && dout_valid);
      wr_acc    = wr_en && !full;
      ovf_evt   = wr_en && full;
      out_take  = 1'b0;
      ram_rd    = 1'b0;
      dv_nxt    = 1'b0;
      unf_evt   = 1'b0;
      if (FWFT != 0) begin
         // The output register counts as storage; RAM refills it
         // whenever it is empty or being consumed this edge.
         out_take = rd_en && dout_valid;
         ram_rd   = (ram_cnt != '0) && (!dout_valid || out_take);
         dv_nxt   = ram_rd || (dout_valid && !out_take);
         unf_evt  = rd_en && !dout_valid;
      end else begin
         out_take = rd_en && !empty;
         ram_rd   = out_take;
         dv_nxt   = out_take;
         unf_evt  = rd_en && empty;
      end
      count_nxt = count + (AW+1)'(wr_acc) - (AW+1)'(out_take);
   end

   // Storage array: written on accepted writes, never reset
   always_ff @(posedge wclk) begin
      if (wr_acc) mem[wr_ptr] <= din;
   end

   // Pointers, output register, occupancy and registered flags
   always_ff @(posedge wclk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         dout         <= '0;
         dout_valid   <= 1'b0;
         count        <= '0;
         full         <= 1'b0;
         almost_full  <= 1'b0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (ram_rd) begin
            rd_ptr <= rd_ptr + AW'(1);
            dout   <= mem[rd_ptr];
         end
         dout_valid   <= dv_nxt;
         count        <= count_nxt;
         full         <= (count_nxt == CNT_FULL);
         almost_full  <= (count_nxt >= CNT_AF);
         empty        <= (count_nxt == '0);
         almost_empty <= (count_nxt <= CNT_AE);
         // A new error in the clearing cycle keeps the flag set
         overflow     <= ovf_evt || (overflow && !clr_err);
         underflow    <= unf_evt || (underflow && !clr_err);
      end
   end

endmodule

// File: tb/tb_okdram_fifo.sv
// tb_okdram_fifo: directed checks of okdram_fifo in standard mode (64x8)
// and first-word-fall-through mode (16x8).
module tb_okdram_fifo;

   typedef struct {
      logic       wr;
      logic       rd;
      logic       clr;
      logic [7:0] din;
      logic       chkd;
      logic [7:0] dout;
      logic       dv;
      logic [4:0] cnt;
      logic       full;
      logic       af;
      logic       em;
      logic       ae;
      logic       ov;
      logic       un;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0_n = 1'b1;
   logic       wr0 = 1'b0, rd0 = 1'b0, clr0 = 1'b0;
   logic [7:0] din0 = 8'h00;
   logic [7:0] dout0;
   logic       dv0, full0, af0, em0, ae0, ov0, un0;
   logic [6:0] cnt0;

   logic       rst1_n = 1'b1;
   logic       wr1 = 1'b0, rd1 = 1'b0, clr1 = 1'b0;
   logic [7:0] din1 = 8'h00;
   logic [7:0] dout1;
   logic       dv1, full1, af1, em1, ae1, ov1, un1;
   logic [4:0] cnt1;

   int checks = 0;
   int errors = 0;

   okdram_fifo #(.WIDTH(8), .AW(6), .FWFT(0)) u0 (
      .wclk(clk), .rst_n(rst0_n), .wr_en(wr0), .din(din0),
      .rd_en(rd0), .clr_err(clr0), .dout(dout0), .dout_valid(dv0),
      .full(full0), .almost_full(af0), .empty(em0),
      .almost_empty(ae0), .count(cnt0), .overflow(ov0),
      .underflow(un0)
   );

   okdram_fifo #(.WIDTH(8), .AW(4), .FWFT(1)) u1 (
      .wclk(clk), .rst_n(rst1_n), .wr_en(wr1), .din(din1),
      .rd_en(rd1), .clr_err(clr1), .dout(dout1), .dout_valid(dv1),
      .full(full1), .almost_full(af1), .empty(em1),
      .almost_empty(ae1), .count(cnt1), .overflow(ov1),
      .underflow(un1)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(int wr, int rd, int clr, int din,
                               int chkd, int dout, int dv, int cnt,
                               int full, int af, int em, int ae,
                               int ov, int un);
      vec_t r;
      r.wr   = 1'(wr);
      r.rd   = 1'(rd);
      r.clr  = 1'(clr);
      r.din  = 8'(din);
      r.chkd = 1'(chkd);
      r.dout = 8'(dout);
      r.dv   = 1'(dv);
      r.cnt  = 5'(cnt);
      r.full = 1'(full);
      r.af   = 1'(af);
      r.em   = 1'(em);
      r.ae   = 1'(ae);
      r.ov   = 1'(ov);
      r.un   = 1'(un);
      return r;
   endfunction

   vec_t       tv[$];
   logic [7:0] q[$];
   logic [7:0] v;
   logic [7:0] e;

   initial begin
      // FWFT table: wr rd clr din | chkd dout dv cnt full af em ae ov un
      tv.push_back(mk(1,0,0,'hA5, 0,'h00,0, 1, 0,0,0,1, 0,0));
      tv.push_back(mk(0,0,0,'h00, 1,'hA5,1, 1, 0,0,0,1, 0,0));
      tv.push_back(mk(0,1,0,'h00, 1,'hA5,0, 0, 0,0,1,1, 0,0));
      tv.push_back(mk(0,1,0,'h00, 0,'h00,0, 0, 0,0,1,1, 0,1));
      tv.push_back(mk(0,0,1,'h00, 0,'h00,0, 0, 0,0,1,1, 0,0));
      tv.push_back(mk(1,1,0,'h10, 0,'h00,0, 1, 0,0,0,1, 0,1));
      tv.push_back(mk(1,0,0,'h11, 1,'h10,1, 2, 0,0,0,1, 0,1));
      tv.push_back(mk(0,0,1,'h00, 1,'h10,1, 2, 0,0,0,1, 0,0));
      for (int k = 0; k < 14; k++)
         tv.push_back(mk(1,0,0,'h12+k, 1,'h10,1, 3+k,
                         int'(k == 13), int'(3+k >= 12), 0,
                         int'(3+k <= 4), 0,0));
      tv.push_back(mk(1,0,0,'h20, 1,'h10,1,16, 1,1,0,0, 1,0));
      tv.push_back(mk(1,1,0,'h21, 1,'h11,1,15, 0,1,0,0, 1,0));
      tv.push_back(mk(1,0,0,'h22, 1,'h11,1,16, 1,1,0,0, 1,0));
      tv.push_back(mk(1,0,1,'h23, 1,'h11,1,16, 1,1,0,0, 1,0));
      tv.push_back(mk(0,0,1,'h00, 1,'h11,1,16, 1,1,0,0, 0,0));
      for (int k = 1; k <= 16; k++)
         tv.push_back(mk(0,1,0,'h00, 1,
                         (k <= 14) ? 'h11+k : 'h22, int'(k < 16),
                         16-k, 0, int'(16-k >= 12), int'(k == 16),
                         int'(16-k <= 4), 0,0));

      // Reset both instances
      #2;
      rst0_n = 1'b0;
      rst1_n = 1'b0;
      tick;
      tick;
      chk("rst_dout", dout0, 0);
      chk("rst_dv", dv0, 0);
      chk("rst_cnt", cnt0, 0);
      chk("rst_empty", em0, 1);
      chk("rst_aempty", ae0, 1);
      chk("rst_full", full0, 0);
      chk("rst_afull", af0, 0);
      chk("rst_ov", ov0, 0);
      chk("rst_un", un0, 0);
      chk("rst1_cnt", cnt1, 0);
      chk("rst1_dv", dv1, 0);
      chk("rst1_empty", em1, 1);
      rst0_n = 1'b1;
      rst1_n = 1'b1;
      tick;

      // FWFT table
      foreach (tv[n]) begin
         wr1  = tv[n].wr;
         rd1  = tv[n].rd;
         clr1 = tv[n].clr;
         din1 = tv[n].din;
         tick;
         if (tv[n].chkd) chk($sformatf("t%0d_dout", n), dout1, tv[n].dout);
         chk($sformatf("t%0d_dv", n), dv1, tv[n].dv);
         chk($sformatf("t%0d_cnt", n), cnt1, tv[n].cnt);
         chk($sformatf("t%0d_full", n), full1, tv[n].full);
         chk($sformatf("t%0d_af", n), af1, tv[n].af);
         chk($sformatf("t%0d_empty", n), em1, tv[n].em);
         chk($sformatf("t%0d_ae", n), ae1, tv[n].ae);
         chk($sformatf("t%0d_ov", n), ov1, tv[n].ov);
         chk($sformatf("t%0d_un", n), un1, tv[n].un);
      end
      wr1  = 1'b0;
      rd1  = 1'b0;
      clr1 = 1'b0;

      // Standard mode: fill to full
      for (int i = 1; i <= 64; i++) begin
         wr0  = 1'b1;
         din0 = 8'(i);
         tick;
         chk("fill_cnt", cnt0, i);
         chk("fill_full", full0, 32'(i == 64));
         chk("fill_af", af0, 32'(i >= 60));
         chk("fill_ae", ae0, 32'(i <= 4));
         chk("fill_empty", em0, 0);
      end
      din0 = 8'h41;
      tick;
      wr0 = 1'b0;
      chk("ovf_cnt", cnt0, 64);
      chk("ovf_flag", ov0, 1);
      chk("ovf_full", full0, 1);

      // Drain with one-cycle valid pulses
      for (int i = 1; i <= 64; i++) begin
         rd0 = 1'b1;
         tick;
         rd0 = 1'b0;
         chk("rd_dout", dout0, i);
         chk("rd_dv", dv0, 1);
         chk("rd_cnt", cnt0, 64 - i);
         tick;
         chk("rd_dv_pulse", dv0, 0);
         chk("rd_hold", dout0, i);
      end
      chk("drain_empty", em0, 1);
      chk("drain_ae", ae0, 1);
      rd0 = 1'b1;
      tick;
      rd0 = 1'b0;
      chk("unf_flag", un0, 1);
      chk("unf_dv", dv0, 0);
      chk("unf_hold", dout0, 8'h40);

      // Clear, then simultaneous write/read at empty
      clr0 = 1'b1;
      tick;
      clr0 = 1'b0;
      chk("clr_ov", ov0, 0);
      chk("clr_un", un0, 0);
      wr0  = 1'b1;
      rd0  = 1'b1;
      din0 = 8'h55;
      tick;
      wr0 = 1'b0;
      rd0 = 1'b0;
      chk("wr_rd_empty_cnt", cnt0, 1);
      chk("wr_rd_empty_un", un0, 1);
      chk("wr_rd_empty_dv", dv0, 0);
      chk("wr_rd_empty_em", em0, 0);
      rd0 = 1'b1;
      tick;
      rd0 = 1'b0;
      chk("wr_rd_empty_dout", dout0, 8'h55);
      chk("wr_rd_empty_cnt2", cnt0, 0);

      // Streaming at constant occupancy across pointer wrap
      v = 8'h60;
      for (int i = 0; i < 10; i++) begin
         wr0  = 1'b1;
         din0 = v;
         q.push_back(v);
         v++;
         tick;
      end
      wr0 = 1'b0;
      chk("stream_cnt0", cnt0, 10);
      for (int i = 0; i < 200; i++) begin
         wr0  = 1'b1;
         rd0  = 1'b1;
         din0 = v;
         e    = q.pop_front();
         q.push_back(v);
         v++;
         tick;
         chk("stream_dout", dout0, e);
         chk("stream_dv", dv0, 1);
         chk("stream_cnt", cnt0, 10);
      end
      rd0 = 1'b0;

      // Grow to 30, then async reset mid-burst
      for (int i = 0; i < 20; i++) begin
         din0 = v;
         v++;
         tick;
      end
      chk("burst_cnt", cnt0, 30);
      #2;
      rst0_n = 1'b0;
      #1;
      chk("arst_dout", dout0, 0);
      chk("arst_dv", dv0, 0);
      chk("arst_cnt", cnt0, 0);
      chk("arst_empty", em0, 1);
      chk("arst_ae", ae0, 1);
      chk("arst_full", full0, 0);
      chk("arst_af", af0, 0);
      chk("arst_un", un0, 0);
      chk("arst_ov", ov0, 0);
      wr0 = 1'b0;
      tick;
      rst0_n = 1'b1;
      tick;
      wr0  = 1'b1;
      din0 = 8'hC1;
      tick;
      din0 = 8'hC2;
      tick;
      wr0 = 1'b0;
      chk("post_rst_cnt", cnt0, 2);
      rd0 = 1'b1;
      tick;
      chk("post_rst_d1", dout0, 8'hC1);
      tick;
      rd0 = 1'b0;
      chk("post_rst_d2", dout0, 8'hC2);
      chk("post_rst_cnt2", cnt0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
